// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the load/store (MEM) stage.
//   - ALU selector value for the load/store class and the memory opcodes
//   - exception codes reported on mem_exc_o
//   - FSM state type
//   - opcode classification helpers
// Optional feature macro: MEM_LSU_LLSC_EN (LL/SC become memory ops).
package mem_lsu_pkg;

    localparam logic [2:0] LS_ALUSEL = 3'b110;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;
    localparam logic [7:0] OP_LL  = 8'h30;
    localparam logic [7:0] OP_SC  = 8'h38;

    localparam logic [1:0] EXC_NONE      = 2'b00;
    localparam logic [1:0] EXC_LOAD_MIS  = 2'b01;
    localparam logic [1:0] EXC_STORE_MIS = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT   = 2'b11;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
`ifdef MEM_LSU_LLSC_EN
            OP_LL:                               is_load = 1'b1;
`endif
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
`ifdef MEM_LSU_LLSC_EN
            OP_SC:               is_store = 1'b1;
`endif
            default:             is_store = 1'b0;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words (incl. LL/SC) need addr[1:0]=0.
    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH:       misaligned = addr_lo[0];
            OP_LW, OP_SW, OP_LL, OP_SC: misaligned = (addr_lo != 2'b00);
            default:                    misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational big-endian lane steering.
//   op         in  8   memory opcode
//   addr_lo    in  2   address bits [1:0]
//   store_data in  32  register value to store
//   load_data  in  32  raw RAM read word
//   sel        out 4   byte-lane enables, bit3 = bits[31:24]
//   wdata      out 32  store data replicated across all lanes
//   load_value out 32  extracted and sign/zero-extended load result
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    always_comb begin
        // Byte at address offset 0 lives on the most significant lane.
        case (addr_lo)
            2'b00:   byte_val = load_data[31:24];
            2'b01:   byte_val = load_data[23:16];
            2'b10:   byte_val = load_data[15:8];
            default: byte_val = load_data[7:0];
        endcase
        half_val = addr_lo[1] ? load_data[15:0] : load_data[31:16];
        byte_sel = 4'b1000 >> addr_lo;
        half_sel = addr_lo[1] ? 4'b0011 : 4'b1100;

        sel        = 4'b1111;
        wdata      = store_data;
        load_value = load_data;
        case (op)
            OP_LB: begin
                sel        = byte_sel;
                load_value = {{24{byte_val[7]}}, byte_val};
            end
            OP_LBU: begin
                sel        = byte_sel;
                load_value = {24'h0, byte_val};
            end
            OP_LH: begin
                sel        = half_sel;
                load_value = {{16{half_val[15]}}, half_val};
            end
            OP_LHU: begin
                sel        = half_sel;
                load_value = {16'h0, half_val};
            end
            OP_SB: begin
                sel   = byte_sel;
                wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                sel   = half_sel;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: multi-cycle MEM stage between EX and WB.
//   EX side : ex_valid/ex_ready accept handshake (transfer when both high),
//             ex_we/ex_waddr/ex_wdata, alusel_i, aluop_i, ram_addr_i, reg2_i
//   RAM side: ram_req_o held until the single-cycle ram_ack_i; ram_we_o,
//             ram_addr_o, ram_sel_o, ram_wdata_o stable while requesting;
//             ram_rdata_i valid with ack
//   WB side : mem_valid one-cycle pulse with mem_we/mem_waddr/mem_wdata and
//             mem_exc_o; all mem_* hold between pulses
//   llbit_clr_i / llbit_o : LL bit control and status
// Optional feature macro: MEM_LSU_LLSC_EN (LL/SC support and LL bit).
module mem_lsu_stage
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_we,
    input  logic [4:0]        ex_waddr,
    input  logic [31:0]       ex_wdata,
    input  logic [2:0]        alusel_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [31:0]       reg2_i,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_wdata_o,
    input  logic              ram_ack_i,
    input  logic [31:0]       ram_rdata_i,
    input  logic              llbit_clr_i,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [4:0]        mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_exc_o,
    output logic              llbit_o
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       op_q;
    logic             we_q;
    logic [4:0]       waddr_q;

    logic             accept;
    logic             ld_op;
    logic             st_op;
    logic             mis_op;
    logic             sc_fail;
    logic [3:0]       req_sel;
    logic [31:0]      req_wdata;
    logic [31:0]      rsp_value;
    logic [31:0]      unused_req_load;
    logic [3:0]       unused_rsp_sel;
    logic [31:0]      unused_rsp_wdata;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign ld_op    = (alusel_i == LS_ALUSEL) && is_load(aluop_i);
    assign st_op    = (alusel_i == LS_ALUSEL) && is_store(aluop_i);
    assign mis_op   = misaligned(aluop_i, ram_addr_i[1:0]);
    assign cnt_inc  = cnt + 1'b1;

`ifdef MEM_LSU_LLSC_EN
    logic llbit_q;
    // SC without a live reservation completes locally with result 0.
    assign sc_fail = st_op && (aluop_i == OP_SC) && !llbit_q;
    assign llbit_o = llbit_q;

    // Clear request beats a simultaneous LL completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            llbit_q <= 1'b0;
        end else if (llbit_clr_i) begin
            llbit_q <= 1'b0;
        end else if (state == ACCESS && ram_ack_i && op_q == OP_LL) begin
            llbit_q <= 1'b1;
        end else if (state == ACCESS && ram_ack_i && op_q == OP_SC) begin
            llbit_q <= 1'b0;
        end
    end
`else
    logic unused_llbit_clr;
    assign unused_llbit_clr = llbit_clr_i;
    assign sc_fail          = 1'b0;
    assign llbit_o          = 1'b0;
`endif

    // Request build from the EX operands.
    mem_lsu_align u_req_align (
        .op         (aluop_i),
        .addr_lo    (ram_addr_i[1:0]),
        .store_data (reg2_i),
        .load_data  (32'h0),
        .sel        (req_sel),
        .wdata      (req_wdata),
        .load_value (unused_req_load)
    );

    // Response extract from the held request and the RAM read word.
    mem_lsu_align u_rsp_align (
        .op         (op_q),
        .addr_lo    (ram_addr_o[1:0]),
        .store_data (32'h0),
        .load_data  (ram_rdata_i),
        .sel        (unused_rsp_sel),
        .wdata      (unused_rsp_wdata),
        .load_value (rsp_value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_sel_o   <= '0;
            ram_wdata_o <= '0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            mem_exc_o   <= EXC_NONE;
        end else begin
            mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if ((ld_op || st_op) && mis_op) begin
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_waddr <= ex_waddr;
                            mem_wdata <= '0;
                            mem_exc_o <= ld_op ? EXC_LOAD_MIS : EXC_STORE_MIS;
                        end else if (sc_fail) begin
                            mem_valid <= 1'b1;
                            mem_we    <= ex_we;
                            mem_waddr <= ex_waddr;
                            mem_wdata <= '0;
                            mem_exc_o <= EXC_NONE;
                        end else if (ld_op || st_op) begin
                            state       <= ACCESS;
                            cnt         <= '0;
                            op_q        <= aluop_i;
                            we_q        <= ex_we;
                            waddr_q     <= ex_waddr;
                            ram_req_o   <= 1'b1;
                            ram_we_o    <= st_op;
                            ram_addr_o  <= ram_addr_i;
                            ram_sel_o   <= req_sel;
                            ram_wdata_o <= st_op ? req_wdata : 32'h0;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= ex_we;
                            mem_waddr <= ex_waddr;
                            mem_wdata <= ex_wdata;
                            mem_exc_o <= EXC_NONE;
                        end
                    end
                end
                ACCESS: begin
                    if (ram_ack_i) begin
                        state     <= IDLE;
                        ram_req_o <= 1'b0;
                        ram_we_o  <= 1'b0;
                        mem_valid <= 1'b1;
                        mem_waddr <= waddr_q;
                        mem_exc_o <= EXC_NONE;
                        if (ram_we_o) begin
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
`ifdef MEM_LSU_LLSC_EN
                            if (op_q == OP_SC) begin
                                mem_we    <= we_q;
                                mem_wdata <= 32'd1;
                            end
`endif
                        end else begin
                            mem_we    <= we_q;
                            mem_wdata <= rsp_value;
                        end
                    end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                        state     <= IDLE;
                        ram_req_o <= 1'b0;
                        ram_we_o  <= 1'b0;
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_waddr <= waddr_q;
                        mem_wdata <= '0;
                        mem_exc_o <= EXC_TIMEOUT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb_mem_lsu_stage: self-checking bench for mem_lsu_stage with a
// transaction-level reference model. Honors MEM_LSU_LLSC_EN when defined.
module tb_mem_lsu_stage;

    localparam int TMO = 8;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic [2:0]  alusel_i;
    logic [7:0]  aluop_i;
    logic [31:0] ram_addr_i;
    logic [31:0] reg2_i;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o;
    logic        ram_ack_i;
    logic [31:0] ram_rdata_i;
    logic        llbit_clr_i;
    logic        mem_valid;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_exc_o;
    logic        llbit_o;

    int          total;
    int          bad;
    logic        model_ll;
    logic [39:0] exp_q[$];   // {we, waddr, wdata, exc}
    logic [7:0]  op_tab [12];

    mem_lsu_stage #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_we       (ex_we),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .alusel_i    (alusel_i),
        .aluop_i     (aluop_i),
        .ram_addr_i  (ram_addr_i),
        .reg2_i      (reg2_i),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_sel_o   (ram_sel_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_ack_i   (ram_ack_i),
        .ram_rdata_i (ram_rdata_i),
        .llbit_clr_i (llbit_clr_i),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_exc_o   (mem_exc_o),
        .llbit_o     (llbit_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // kind: 0 = passthrough, 1 = immediate result without request, 2 = RAM access
    function automatic void model(
        input  logic [2:0]  cls, input logic [7:0] op, input logic [31:0] addr,
        input  logic [31:0] src, input logic [31:0] alu, input logic we,
        input  logic [4:0]  dst, input logic [31:0] rdata, input logic tmo,
        output int kind, output logic [3:0] e_sel, output logic [31:0] e_wd,
        output logic e_rwe, output logic [39:0] res);
        int   size;
        int   bo;
        bit   ld;
        bit   st;
        logic [7:0]  bv;
        logic [15:0] hv;
        logic [31:0] lv;
        size = 0; ld = 0; st = 0;
        case (op)
            8'h20, 8'h24: begin ld = 1; size = 1; end
            8'h21, 8'h25: begin ld = 1; size = 2; end
            8'h23:        begin ld = 1; size = 4; end
            8'h28:        begin st = 1; size = 1; end
            8'h29:        begin st = 1; size = 2; end
            8'h2B:        begin st = 1; size = 4; end
`ifdef MEM_LSU_LLSC_EN
            8'h30:        begin ld = 1; size = 4; end
            8'h38:        begin st = 1; size = 4; end
`endif
            default: ;
        endcase
        bo    = int'(addr[1:0]);
        e_rwe = st;
        e_sel = 4'hF;
        e_wd  = src;
        if (size == 1) begin
            e_sel = 4'(8 >> bo);
            e_wd  = {4{src[7:0]}};
        end else if (size == 2) begin
            e_sel = (bo == 2) ? 4'b0011 : 4'b1100;
            e_wd  = {2{src[15:0]}};
        end
        bv = 8'(rdata >> (24 - 8 * bo));
        hv = 16'(rdata >> ((bo == 2) ? 0 : 16));
        case (op)
            8'h20:   lv = 32'($signed(bv));
            8'h24:   lv = {24'h0, bv};
            8'h21:   lv = 32'($signed(hv));
            8'h25:   lv = {16'h0, hv};
            default: lv = rdata;
        endcase
        if (cls != 3'b110 || !(ld || st)) begin
            kind = 0; res = {we, dst, alu, 2'b00};
        end else if (bo % size != 0) begin
            kind = 1; res = {1'b0, dst, 32'h0, ld ? 2'b01 : 2'b10};
        end else if (op == 8'h38 && !model_ll) begin
            kind = 1; res = {we, dst, 32'h0, 2'b00};
        end else begin
            kind = 2;
            if (tmo)             res = {1'b0, dst, 32'h0, 2'b11};
            else if (op == 8'h38) res = {we, dst, 32'h1, 2'b00};
            else if (st)         res = {1'b0, dst, 32'h0, 2'b00};
            else                 res = {we, dst, lv, 2'b00};
        end
    endfunction

    // ---------------- driver tasks ----------------
    // delay = cycles from accept to ack (>=1); 0 = RAM never answers.
    task automatic issue(input logic [2:0] cls, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] src, input logic [31:0] alu, input logic we,
                         input logic [4:0] dst, input logic [31:0] rdata, input int delay);
        int          kind;
        int          guard;
        logic [3:0]  e_sel;
        logic [31:0] e_wd;
        logic        e_rwe;
        logic [39:0] res;
        logic [39:0] got;
        model(cls, op, addr, src, alu, we, dst, rdata, (delay == 0), kind, e_sel, e_wd, e_rwe, res);
        exp_q.push_back(res);
        @(negedge clk);
        guard = 0;
        while (!ex_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", ex_ready, 1);
        ex_valid = 1; alusel_i = cls; aluop_i = op; ram_addr_i = addr;
        reg2_i = src; ex_wdata = alu; ex_we = we; ex_waddr = dst;
        @(posedge clk); #1;
        ex_valid = 0; ex_wdata = $urandom; reg2_i = $urandom;
        if (kind == 2) begin
            check("busy", ex_ready, 0);
            check("req_on", ram_req_o, 1);
            check("req_we", ram_we_o, e_rwe);
            check("req_addr", ram_addr_o, addr);
            check("req_sel", ram_sel_o, e_sel);
            if (e_rwe) check("req_wdata", ram_wdata_o, e_wd);
            if (delay == 0) begin
                for (int i = 1; i < TMO; i++) begin
                    @(posedge clk); #1;
                    check("tmo_hold", ram_req_o, 1);
                end
                @(posedge clk); #1;
            end else begin
                for (int i = 1; i < delay; i++) begin
                    @(posedge clk); #1;
                    check("req_hold", {ram_req_o, ram_sel_o}, {1'b1, e_sel});
                end
                ram_ack_i = 1; ram_rdata_i = rdata;
                @(posedge clk); #1;
                ram_ack_i = 0; ram_rdata_i = $urandom;
            end
            check("req_off", ram_req_o, 0);
        end else begin
            check("no_req", ram_req_o, 0);
        end
        got = {mem_we, mem_waddr, mem_wdata, mem_exc_o};
        check("valid", mem_valid, 1);
        check($sformatf("result op=%0h addr=%0h", op, addr), got, exp_q.pop_front());
        check("ready_back", ex_ready, 1);
`ifdef MEM_LSU_LLSC_EN
        if (kind == 2 && delay != 0 && op == 8'h30) model_ll = 1;
        if (kind == 2 && delay != 0 && op == 8'h38) model_ll = 0;
`endif
        check("llbit", llbit_o, model_ll);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        llbit_clr_i = 1;
        @(negedge clk);
        llbit_clr_i = 0;
        model_ll = 0;
        check("llbit_clr", llbit_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  r_op;
        logic [2:0]  r_cls;
        logic [31:0] r_addr;
        int          r_dly;
        total = 0; bad = 0; model_ll = 0;
        op_tab = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h28,
                   8'h29, 8'h2B, 8'h30, 8'h38, 8'h11, 8'h30};
        reset_n = 0; ex_valid = 0; ex_we = 0; ex_waddr = 0; ex_wdata = 0;
        alusel_i = 0; aluop_i = 0; ram_addr_i = 0; reg2_i = 0;
        ram_ack_i = 0; ram_rdata_i = 0; llbit_clr_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ex_ready, 1);
        check("rst_req", ram_req_o, 0);
        check("rst_valid", mem_valid, 0);
        check("rst_mem", {mem_we, mem_waddr, mem_wdata, mem_exc_o}, 0);
        check("rst_ram", {ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o}, 0);
        check("rst_llbit", llbit_o, 0);
        @(negedge clk);
        reset_n = 1;

        // ALU passthrough, then hold after the pulse
        issue(3'b001, 8'h21, 32'h0, 32'h0, 32'h12345678, 1, 5'd5, 32'h0, 1);
        @(posedge clk); #1;
        check("pulse_drop", mem_valid, 0);
        check("hold_wdata", mem_wdata, 32'h12345678);
        // back-to-back passthrough
        issue(3'b000, 8'h00, 32'h0, 32'h0, 32'hCAFEF00D, 0, 5'd9, 32'h0, 1);
        issue(3'b011, 8'h05, 32'h0, 32'h0, 32'h0000_0042, 1, 5'd1, 32'h0, 1);

        // byte loads with 3-cycle latency
        issue(3'b110, 8'h20, 32'h1000_0001, 32'h0, 32'h0, 1, 5'd3, 32'h0080_0000, 3);
        issue(3'b110, 8'h24, 32'h1000_0001, 32'h0, 32'h0, 1, 5'd3, 32'h0080_0000, 3);
        // halfword store on the low lanes
        issue(3'b110, 8'h29, 32'h2000_0002, 32'h0000_BEEF, 32'h0, 1, 5'd4, 32'h0, 2);
        // misaligned load / store
        issue(3'b110, 8'h23, 32'h3000_0002, 32'h0, 32'h0, 1, 5'd6, 32'h0, 1);
        issue(3'b110, 8'h2B, 32'h3000_0001, 32'h0, 32'h0, 1, 5'd7, 32'h0, 1);
        // bus timeout
        issue(3'b110, 8'h23, 32'h4000_0000, 32'h0, 32'h0, 1, 5'd8, 32'h0, 0);
        // fastest ack
        issue(3'b110, 8'h25, 32'h5000_0002, 32'h0, 32'h0, 1, 5'd2, 32'hAAAA_8001, 1);

        // LL/SC sequences (passthrough when the feature is absent)
        issue(3'b110, 8'h30, 32'h6000_0000, 32'h0, 32'h77, 1, 5'd10, 32'h1357_9BDF, 2);
        issue(3'b110, 8'h38, 32'h6000_0000, 32'h5555_0000, 32'h88, 1, 5'd11, 32'h0, 2);
        issue(3'b110, 8'h30, 32'h6000_0004, 32'h0, 32'h99, 1, 5'd12, 32'h2468_ACE0, 1);
        pulse_clr();
        issue(3'b110, 8'h38, 32'h6000_0004, 32'h1, 32'hAB, 1, 5'd13, 32'h0, 2);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            r_op   = op_tab[$urandom_range(0, 11)];
            r_cls  = ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b110;
            r_addr = {$urandom, 2'b00} | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
            r_dly  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 5);
            if ($urandom_range(0, 9) == 0) pulse_clr();
            issue(r_cls, r_op, r_addr, $urandom, $urandom, 1'($urandom),
                  5'($urandom), $urandom, r_dly);
        end

        // reset asserted in the middle of an access
        @(negedge clk);
        ex_valid = 1; alusel_i = 3'b110; aluop_i = 8'h23; ram_addr_i = 32'h0000_0100;
        @(posedge clk); #1;
        ex_valid = 0;
        check("mid_req", ram_req_o, 1);
        @(posedge clk); #3;
        reset_n = 0;
        #1;
        check("async_req", ram_req_o, 0);
        check("async_ready", ex_ready, 1);
        check("async_valid", mem_valid, 0);
        model_ll = 0;
        check("async_llbit", llbit_o, model_ll);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk); #1;
        check("post_rst_req", ram_req_o, 0);
        check("post_rst_valid", mem_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
